volume_ctrl: RTL and testbench
==============================

# volume_ctrl

Parametrised multi-mode volume controller between the front-panel button inputs and the audio output scaler and display driver. Turns up/down/mute button levels into a saturating volume level with configurable range and step. Adds hold-to-repeat stepping and mute with restore of the previous level. Presents the effective volume in binary and as two BCD digits, plus a one-cycle change strobe.

## Interface

Parameters:
- VOL_MAX, 10: maximum level; legal range 1..99.
- VOL_INIT, 5: level after reset; must be ≤ VOL_MAX.
- STEP, 1: increment/decrement per action; legal range 1..VOL_MAX.
- HOLD_CYCLES, 8: cycles a button must stay held before the first auto-repeat step; must be ≥ 2.
- REPEAT_CYCLES, 4: cycles between subsequent auto-repeat steps; must be ≥ 1.
- VOL_W (localparam): $clog2(VOL_MAX+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- up  in  1  volume-up button level, already synchronised and debounced.
- down  in  1  volume-down button level.
- mute  in  1  mute-toggle button level.
- volume  out  VOL_W  effective volume: 0 when muted, else level.
- vol_tens  out  4  BCD tens digit of volume.
- vol_ones  out  4  BCD ones digit of volume.
- muted  out  1  mute flag.
- changed  out  1  one-cycle pulse on a change of volume or muted.

## Operation

- Internal state: level (VOL_W bits), muted flag, FSM state, hold counter, repeated flag.
- FSM states: IDLE, UP_HELD, DOWN_HELD, MUTE_HELD.
- IDLE exits, priority up > down > mute:
  - up=1 -> UP_HELD.
  - else down=1 -> DOWN_HELD.
  - else mute=1 -> MUTE_HELD.
  - On every exit from IDLE: counter=0, repeated=0.
- In any HELD state, the other buttons are ignored.
- UP_HELD/DOWN_HELD while the button stays at 1:
  - counter increments every edge.
  - If repeated=0 and counter==HOLD_CYCLES-1: apply action, counter=0, repeated=1.
  - If repeated=1 and counter==REPEAT_CYCLES-1: apply action, counter=0.
- UP_HELD/DOWN_HELD on the edge sampling the button at 0:
  - If repeated=0, apply action once.
  - Return to IDLE.
- MUTE_HELD: no auto-repeat. On the edge sampling mute=0, toggle muted and return to IDLE.
- Up action:
  - If muted: clear muted, leave level unchanged.
  - Else: level = min(level+STEP, VOL_MAX), computed in VOL_W+1 bits.
- Down action:
  - If muted: clear muted, leave level unchanged.
  - Else: level = level-STEP, saturating at 0.
- Mute toggle never modifies level, so unmuting restores the pre-mute level.
- Saturation boundaries:
  - An action at a bound that changes nothing produces no changed pulse.
  - Auto-repeat continues counting while saturated.
- Outputs:
  - volume, vol_tens = volume/10, and vol_ones = volume%10 are combinational from registered level and muted.
  - changed is registered: high for exactly the cycle after any edge where volume or muted changed.

## Timing

- Reset values: level=VOL_INIT, muted=0, state=IDLE, counter=0, repeated=0, changed=0.
- Reset outputs: volume=VOL_INIT, with vol_tens and vol_ones giving the matching BCD.
- Reset asserted mid-hold aborts the action immediately. No step is applied.
- Short press: the press is detected on edge E0. The step is applied on the first edge sampling release. changed is high in the following cycle.
- Long hold, counting edges after E0 with the button still high:
  - First step at edge HOLD_CYCLES.
  - Then a step every REPEAT_CYCLES edges.
  - No extra step on release.
- Press and release of the same button within a single sample are not detected (inputs are debounced upstream).
- Back-to-back presses: after release, IDLE re-samples on the next edge. The minimum press-to-press period is 2 cycles.
- Simultaneous up+down in IDLE: up wins. down is ignored until return to IDLE.

## Test plan

Defaults throughout: VOL_MAX=10, VOL_INIT=5, STEP=1, HOLD_CYCLES=8, REPEAT_CYCLES=4.

- Reset, then one short up press of 3 cycles -> volume 5->6; vol_tens=0, vol_ones=6; changed high for exactly 1 cycle after the release edge.
- up held for 20 edges after E0, then released -> steps at edges 8, 12, 16, 20; volume 9; no step on release; 4 changed pulses.
- From level 9, up held for 30 edges -> volume 10 with vol_tens=1, vol_ones=0; a single changed pulse; no wrap past 10.
- mute press -> volume 0 and muted=1; short down press -> muted=0, volume restored to 5 with no decrement; a second down -> 4.
- up and down asserted in the same cycle, short press -> volume +1 only; down ignored while held.
- reset pulse mid-hold at edge 6 -> volume=5, muted=0, changed=0; a release after reset causes no step.

Source files
------------

// File: rtl/volume_ctrl.sv
// Front-panel volume controller: up/down/mute buttons drive a saturating level
// with hold-to-repeat, mute with level restore, binary and BCD outputs.
module volume_ctrl #(
  parameter int VOL_MAX       = 10,
  parameter int VOL_INIT      = 5,
  parameter int STEP          = 1,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 4,
  localparam int VOL_W        = $clog2(VOL_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             mute,
  output logic [VOL_W-1:0] volume,
  output logic [3:0]       vol_tens,
  output logic [3:0]       vol_ones,
  output logic             muted,
  output logic             changed
);

  typedef enum logic [1:0] {IDLE, UP_HELD, DOWN_HELD, MUTE_HELD} state_t;

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [VOL_W:0]   MAX_X     = (VOL_W + 1)'(VOL_MAX);
  localparam logic [VOL_W:0]   STEP_X    = (VOL_W + 1)'(STEP);
  localparam logic [VOL_W-1:0] INIT_V    = VOL_W'(VOL_INIT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rep_q, rep_d;
  logic [VOL_W-1:0]   level_q, level_d;
  logic               muted_q, muted_d;
  logic               changed_q, changed_d;

  logic               btn;
  logic               fire;
  logic               act_up;
  logic               act_down;
  logic               toggle;
  logic [VOL_W:0]     sum_x;
  logic [VOL_W-1:0]   vol_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rep_q     <= 1'b0;
      level_q   <= INIT_V;
      muted_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      level_q   <= level_d;
      muted_q   <= muted_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    level_d   = level_q;
    muted_d   = muted_q;
    btn       = 1'b0;
    fire      = 1'b0;
    act_up    = 1'b0;
    act_down  = 1'b0;
    toggle    = 1'b0;
    sum_x     = {1'b0, level_q} + STEP_X;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        rep_d = 1'b0;
        if (up)        state_d = UP_HELD;
        else if (down) state_d = DOWN_HELD;
        else if (mute) state_d = MUTE_HELD;
      end
      UP_HELD, DOWN_HELD: begin
        btn = (state_q == UP_HELD) ? up : down;
        if (btn) begin
          if (!rep_q && cnt_q == HOLD_LAST) begin
            fire  = 1'b1;
            cnt_d = '0;
            rep_d = 1'b1;
          end else if (rep_q && cnt_q == REP_LAST) begin
            fire  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // A release only steps if auto-repeat never fired during the hold.
          fire    = !rep_q;
          state_d = IDLE;
        end
        act_up   = fire && (state_q == UP_HELD);
        act_down = fire && (state_q == DOWN_HELD);
      end
      MUTE_HELD: begin
        if (!mute) begin
          toggle  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any step while muted only unmutes, so the saved level comes back intact.
    if (act_up || act_down) begin
      if (muted_q) begin
        muted_d = 1'b0;
      end else if (act_up) begin
        level_d = (sum_x > MAX_X) ? MAX_X[VOL_W-1:0] : sum_x[VOL_W-1:0];
      end else begin
        level_d = ({1'b0, level_q} >= STEP_X) ? (level_q - STEP_X[VOL_W-1:0]) : '0;
      end
    end
    if (toggle) muted_d = !muted_q;

    vol_d     = muted_d ? '0 : level_d;
    changed_d = (vol_d != volume) || (muted_d != muted_q);
  end

  assign volume   = muted_q ? '0 : level_q;
  assign vol_tens = 4'(8'(volume) / 8'd10);
  assign vol_ones = 4'(8'(volume) % 8'd10);
  assign muted    = muted_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_volume_ctrl.sv
// Scoreboard bench for volume_ctrl: a behavioural model predicts each changed
// pulse (cycle, volume, mute) at stimulus time; a monitor pops and compares.
module tb_volume_ctrl;

  localparam int VOL_MAX = 10;
  localparam int VOL_INIT = 5;
  localparam int STEP = 1;
  localparam int HOLD = 8;
  localparam int REP = 4;
  localparam int VOL_W = $clog2(VOL_MAX + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             up = 1'b0;
  logic             down = 1'b0;
  logic             mute = 1'b0;
  logic [VOL_W-1:0] volume;
  logic [3:0]       vol_tens;
  logic [3:0]       vol_ones;
  logic             muted;
  logic             changed;

  volume_ctrl #(
    .VOL_MAX(VOL_MAX), .VOL_INIT(VOL_INIT), .STEP(STEP),
    .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset(reset), .up(up), .down(down), .mute(mute),
    .volume(volume), .vol_tens(vol_tens), .vol_ones(vol_ones),
    .muted(muted), .changed(changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int vol;
    int mu;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_level = VOL_INIT;
  int   m_muted = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int m_vol();
    return m_muted ? 0 : m_level;
  endfunction

  task automatic push_if_changed(input int e, input int old_vol, input int old_mu);
    exp_t x;
    if (m_vol() != old_vol || m_muted != old_mu) begin
      x.cyc = e;
      x.vol = m_vol();
      x.mu  = m_muted;
      sb.push_back(x);
    end
  endtask

  task automatic model_step(input int is_up, input int e);
    int ov = m_vol();
    int om = m_muted;
    if (m_muted) m_muted = 0;
    else if (is_up) m_level = (m_level + STEP > VOL_MAX) ? VOL_MAX : m_level + STEP;
    else m_level = (m_level >= STEP) ? m_level - STEP : 0;
    push_if_changed(e, ov, om);
  endtask

  // Hold buttons for E0 plus n further edges, then release.
  task automatic press(input logic u, input logic d, input logic m, input int n);
    int c;
    int ov;
    int om;
    @(posedge clk);
    #1;
    c = cyc;
    up = u;
    down = d;
    mute = m;
    if (u || d) begin
      if (n >= HOLD) begin
        for (int k = HOLD; k <= n; k += REP) model_step(int'(u), c + 1 + k);
      end else begin
        model_step(int'(u), c + n + 2);
      end
    end else if (m) begin
      ov = m_vol();
      om = m_muted;
      m_muted = !m_muted;
      push_if_changed(c + n + 2, ov, om);
    end
    $display("press u=%0b d=%0b m=%0b held=%0d -> model volume=%0d muted=%0d",
             u, d, m, n, m_vol(), m_muted);
    repeat (n + 1) @(posedge clk);
    #1;
    up = 1'b0;
    down = 1'b0;
    mute = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_volume"}, int'(volume), m_vol());
    check({tag, "_muted"}, int'(muted), m_muted);
    check({tag, "_tens"}, int'(vol_tens), m_vol() / 10);
    check({tag, "_ones"}, int'(vol_ones), m_vol() % 10);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  // Monitor: every changed pulse must match the head of the scoreboard in time and value.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      check("missing_changed", 0, 1);
      void'(sb.pop_front());
    end
    if (changed) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        check("sb_volume", int'(volume), sb[0].vol);
        check("sb_muted", int'(muted), sb[0].mu);
        check("sb_tens", int'(vol_tens), sb[0].vol / 10);
        check("sb_ones", int'(vol_ones), sb[0].vol % 10);
        $display("changed cycle=%0d volume=%0d muted=%0d", cyc, volume, muted);
        void'(sb.pop_front());
      end else begin
        check("unexpected_changed", 1, 0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_changed", int'(changed), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");

    press(1'b1, 1'b0, 1'b0, 2);    // short up: 5 -> 6
    check_state("short_up");
    press(1'b0, 1'b1, 1'b0, 1);    // 6 -> 5
    press(1'b1, 1'b0, 1'b0, 20);   // steps at 8,12,16,20 -> 9
    check_state("hold_up20");
    press(1'b1, 1'b0, 1'b0, 30);   // saturates at 10 after one pulse
    check_state("hold_up_sat");
    press(1'b0, 1'b1, 1'b0, 20);   // 10 -> 6
    press(1'b0, 1'b1, 1'b0, 2);    // 6 -> 5
    press(1'b0, 1'b0, 1'b1, 2);    // mute
    check_state("mute_on");
    press(1'b0, 1'b1, 1'b0, 2);    // unmute, level restored
    check_state("unmute_restore");
    press(1'b0, 1'b1, 1'b0, 0);    // 5 -> 4
    check_state("down_after");
    press(1'b1, 1'b1, 1'b0, 3);    // up wins
    check_state("up_down_same");
    press(1'b0, 1'b1, 1'b0, 60);   // saturates at 0
    check_state("hold_down_sat");
    press(1'b0, 1'b0, 1'b1, 1);    // mute at 0: no visible change of volume, flag changes
    press(1'b1, 1'b0, 1'b0, 1);    // unmute only
    press(1'b1, 1'b0, 1'b0, 1);    // 0 -> 1
    check_state("from_zero");

    // Reset after edge 6 of a hold: no step, back to init.
    @(posedge clk);
    #1;
    up = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    m_level = VOL_INIT;
    m_muted = 0;
    check("midrst_changed", int'(changed), 0);
    check_state("midrst");
    up = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check_state("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
